// File: rtl/sum_acc64_pkg.sv
// Shared widths and FSM state encodings for the sum_acc64 accumulator.
package sum_acc64_pkg;

  localparam int WORD_W = 32;
  localparam int ACC_W  = 64;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/sum_acc64_cla_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained group to group.
module cla_32
  import sum_acc64_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c_in,
  output logic [WORD_W-1:0] sum,
  output logic              c_out
);

  logic [WORD_W-1:0] gen;
  logic [WORD_W-1:0] prop;
  logic [WORD_W:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each group computes its internal carries directly from the group carry-in.
  always_comb begin
    carry    = '0;
    carry[0] = c_in;
    for (int k = 0; k < WORD_W / 4; k++) begin
      carry[4*k+1] = gen[4*k] | (prop[4*k] & carry[4*k]);
      carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                   | (prop[4*k+1] & prop[4*k] & carry[4*k]);
      carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
      carry[4*k+4] = gen[4*k+3] | (prop[4*k+3] & gen[4*k+2])
                   | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
    end
  end

  assign sum   = prop ^ carry[WORD_W-1:0];
  assign c_out = carry[WORD_W];

endmodule

// File: rtl/sum_acc64.sv
// Streaming 64-bit accumulator; one shared 32-bit adder does the low word, then the high word.
module sum_acc64
  import sum_acc64_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [WORD_W-1:0] operand;
  logic              c_reg;
  logic              last_flag;
  logic [CNT_W-1:0]  count;

  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic              add_cin;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  // HIGH propagates the stored low-word carry into the upper half; otherwise add the operand.
  always_comb begin
    add_a   = acc[WORD_W-1:0];
    add_b   = operand;
    add_cin = 1'b0;
    if (state == S_HIGH) begin
      add_a   = acc[ACC_W-1:WORD_W];
      add_b   = '0;
      add_cin = c_reg;
    end
  end

  cla_32 adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      acc       <= '0;
      operand   <= '0;
      c_reg     <= 1'b0;
      last_flag <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (in_valid && in_ready) begin
            operand   <= in_data;
            last_flag <= in_last;
            state     <= S_LOW;
          end
        end
        S_LOW: begin
          acc[WORD_W-1:0] <= add_sum;
          c_reg           <= add_cout;
          state           <= S_HIGH;
        end
        S_HIGH: begin
          // Carry out of the high word is dropped so the sum wraps modulo 2^64.
          acc[ACC_W-1:WORD_W] <= add_sum;
          if (count != '1) count <= count + CNT_W'(1);
          state <= last_flag ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            c_reg <= 1'b0;
            state <= S_WAIT;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign in_ready  = (state == S_WAIT);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_LOW) || (state == S_HIGH);
  assign out_sum   = acc;
  assign out_count = count;

endmodule
